// File: rtl/aq_vlsu_seg_trans.sv
// Two-stage VLSU data transform: segment (NF-field) transpose plus byte rotation.
// Stores transpose then rotate; loads rotate then transpose. Valid/ready with flush.
module aq_vlsu_seg_trans #(
  parameter  int DATAW = 64,
  parameter  int TAGW  = 4,
  localparam int ROTW  = $clog2(DATAW/8)
) (
  input  logic             forever_cpuclk_i,
  input  logic             cpurst_i,
  input  logic             flush_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic             in_dir_i,
  input  logic [1:0]       in_sew_i,
  input  logic [1:0]       in_nf_i,
  input  logic [ROTW-1:0]  in_rot_i,
  input  logic [TAGW-1:0]  in_tag_i,
  input  logic [DATAW-1:0] in_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [DATAW-1:0] out_data_o,
  output logic [TAGW-1:0]  out_tag_o,
  output logic             out_err_o
);

  localparam int NB = DATAW/8;

  // log2(E) = log2(bytes per beat) - sew; the layout is legal when log2(NF) <= log2(E).
  function automatic logic is_illegal(input logic [1:0] sew, input logic [1:0] nf);
    logic [2:0] l2e;
    l2e = 3'(ROTW) - {1'b0, sew};
    return ({1'b0, nf} > l2e);
  endfunction

  // Source byte index feeding output byte j of the transpose. Element index k is split
  // into (field, element-in-field) bit fields, so the transpose is a bit-field swap.
  function automatic logic [ROTW-1:0] trans_src(input logic [ROTW-1:0] j,
                                                input logic [1:0]      sew,
                                                input logic [1:0]      nf,
                                                input logic            wr);
    logic [2:0]      l2e;
    logic [2:0]      l2p;
    logic [ROTW-1:0] k;
    logic [ROTW-1:0] src;
    logic [ROTW-1:0] bmask;
    logic [ROTW-1:0] fmask;
    logic [ROTW-1:0] pmask;
    l2e   = 3'(ROTW) - {1'b0, sew};
    l2p   = l2e - {1'b0, nf};
    k     = j >> sew;
    bmask = ~({ROTW{1'b1}} << sew);
    fmask = ~({ROTW{1'b1}} << nf);
    pmask = ~({ROTW{1'b1}} << l2p);
    if (wr) begin
      src = ((k & fmask) << l2p) | (k >> nf);
    end else begin
      src = ((k & pmask) << nf) | (k >> l2p);
    end
    if (is_illegal(sew, nf)) begin
      return j;
    end
    return (src << sew) | (j & bmask);
  endfunction

  // Byte count is a power of two, so the ROTW-bit wrap gives the modulo for free.
  function automatic logic [ROTW-1:0] rot_src(input logic [ROTW-1:0] j,
                                              input logic [ROTW-1:0] rot,
                                              input logic            wr);
    return wr ? (j - rot) : (j + rot);
  endfunction

  logic             s1_vld_q, s1_vld_d;
  logic [DATAW-1:0] s1_data_q, s1_data_d;
  logic             s1_dir_q, s1_dir_d;
  logic [1:0]       s1_sew_q, s1_sew_d;
  logic [1:0]       s1_nf_q, s1_nf_d;
  logic [ROTW-1:0]  s1_rot_q, s1_rot_d;
  logic [TAGW-1:0]  s1_tag_q, s1_tag_d;
  logic             s1_err_q, s1_err_d;

  logic             s2_vld_q, s2_vld_d;
  logic [DATAW-1:0] s2_data_q, s2_data_d;
  logic [TAGW-1:0]  s2_tag_q, s2_tag_d;
  logic             s2_err_q, s2_err_d;

  logic             s2_adv;
  logic             s1_adv;
  logic [7:0]       in_b [NB];
  logic [7:0]       s1_b [NB];
  logic [DATAW-1:0] s1_xf;
  logic [DATAW-1:0] s2_xf;

  assign s2_adv   = !s2_vld_q || out_rdy_i;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_rdy_o = s1_adv;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam logic [ROTW-1:0] J = ROTW'(gi);
      assign in_b[gi] = in_data_i[gi*8 +: 8];
      assign s1_b[gi] = s1_data_q[gi*8 +: 8];
      assign s1_xf[gi*8 +: 8] = in_dir_i
          ? in_b[trans_src(J, in_sew_i, in_nf_i, 1'b1)]
          : in_b[rot_src(J, in_rot_i, 1'b0)];
      assign s2_xf[gi*8 +: 8] = s1_dir_q
          ? s1_b[rot_src(J, s1_rot_q, 1'b1)]
          : s1_b[trans_src(J, s1_sew_q, s1_nf_q, 1'b0)];
    end
  endgenerate

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_dir_d  = s1_dir_q;
    s1_sew_d  = s1_sew_q;
    s1_nf_d   = s1_nf_q;
    s1_rot_d  = s1_rot_q;
    s1_tag_d  = s1_tag_q;
    s1_err_d  = s1_err_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_err_d  = s2_err_q;

    if (s1_adv) begin
      s1_vld_d = in_vld_i;
      if (in_vld_i) begin
        s1_data_d = s1_xf;
        s1_dir_d  = in_dir_i;
        s1_sew_d  = in_sew_i;
        s1_nf_d   = in_nf_i;
        s1_rot_d  = in_rot_i;
        s1_tag_d  = in_tag_i;
        s1_err_d  = is_illegal(in_sew_i, in_nf_i);
      end
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_data_d = s2_xf;
        s2_tag_d  = s1_tag_q;
        s2_err_d  = s1_err_q;
      end
    end

    // Flush kills valids only; any beat accepted this cycle is dropped with them.
    if (flush_i) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk_i or posedge cpurst_i) begin
    if (cpurst_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_dir_q  <= 1'b0;
      s1_sew_q  <= '0;
      s1_nf_q   <= '0;
      s1_rot_q  <= '0;
      s1_tag_q  <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_dir_q  <= s1_dir_d;
      s1_sew_q  <= s1_sew_d;
      s1_nf_q   <= s1_nf_d;
      s1_rot_q  <= s1_rot_d;
      s1_tag_q  <= s1_tag_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign out_vld_o  = s2_vld_q;
  assign out_data_o = s2_data_q;
  assign out_tag_o  = s2_tag_q;
  assign out_err_o  = s2_err_q;

endmodule

// File: tb/tb_aq_vlsu_seg_trans.sv
// Scoreboard bench: 64-bit and 128-bit instances share stimulus; a byte-array reference
// model predicts each accepted beat and a negedge monitor checks every output handshake.
module tb_aq_vlsu_seg_trans;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_dir = 1'b0;
  logic [1:0]   in_sew = '0;
  logic [1:0]   in_nf = '0;
  logic [3:0]   in_rot = '0;
  logic [3:0]   in_tag = '0;
  logic [127:0] in_data = '0;
  logic         out_rdy = 1'b1;

  logic         in_rdy64, out_vld64, out_err64;
  logic [63:0]  out_data64;
  logic [3:0]   out_tag64;
  logic         in_rdy128, out_vld128, out_err128;
  logic [127:0] out_data128;
  logic [3:0]   out_tag128;

  int total = 0;
  int bad = 0;

  logic [68:0]  q64[$];
  logic [132:0] q128[$];
  bit           mon_en = 1'b0;
  int           occ = 0;
  bit           stall_prev = 1'b0;
  logic [68:0]  held64;
  logic [132:0] held128;

  bit           dexp64_en = 1'b0;
  logic [64:0]  dexp64 = '0;
  bit           dexp128_en = 1'b0;
  logic [128:0] dexp128 = '0;
  logic [3:0]   tag_ctr = '0;

  aq_vlsu_seg_trans #(.DATAW(64), .TAGW(4)) u_dut64 (
    .forever_cpuclk_i(clk), .cpurst_i(rst), .flush_i(flush),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy64), .in_dir_i(in_dir),
    .in_sew_i(in_sew), .in_nf_i(in_nf), .in_rot_i(in_rot[2:0]),
    .in_tag_i(in_tag), .in_data_i(in_data[63:0]),
    .out_vld_o(out_vld64), .out_rdy_i(out_rdy), .out_data_o(out_data64),
    .out_tag_o(out_tag64), .out_err_o(out_err64)
  );

  aq_vlsu_seg_trans #(.DATAW(128), .TAGW(4)) u_dut128 (
    .forever_cpuclk_i(clk), .cpurst_i(rst), .flush_i(flush),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy128), .in_dir_i(in_dir),
    .in_sew_i(in_sew), .in_nf_i(in_nf), .in_rot_i(in_rot),
    .in_tag_i(in_tag), .in_data_i(in_data),
    .out_vld_o(out_vld128), .out_rdy_i(out_rdy), .out_data_o(out_data128),
    .out_tag_o(out_tag128), .out_err_o(out_err128)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Returns {err, data}; works on whole elements of S bytes within a byte array of nb bytes.
  function automatic logic [128:0] model(input int nb, input bit dir, input int sew,
                                         input int nf, input int rot, input logic [127:0] d);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   r [16];
    logic [128:0] res;
    int s, e_cnt, nfl, p;
    bit ok;
    s = 1 << sew;
    e_cnt = nb / s;
    nfl = 1 << nf;
    ok = (nfl <= e_cnt);
    p = ok ? e_cnt / nfl : 1;
    rot = rot % nb;
    for (int i = 0; i < 16; i++) begin
      a[i] = (i < nb) ? d[8*i +: 8] : 8'h00;
      t[i] = 8'h00;
      r[i] = 8'h00;
    end
    if (dir) begin
      t = a;
      if (ok)
        for (int f = 0; f < nfl; f++)
          for (int e = 0; e < p; e++)
            for (int b = 0; b < s; b++)
              t[(e*nfl + f)*s + b] = a[(f*p + e)*s + b];
      for (int i = 0; i < nb; i++) r[(i + rot) % nb] = t[i];
    end else begin
      for (int i = 0; i < nb; i++) t[i] = a[(i + rot) % nb];
      r = t;
      if (ok)
        for (int f = 0; f < nfl; f++)
          for (int e = 0; e < p; e++)
            for (int b = 0; b < s; b++)
              r[(f*p + e)*s + b] = t[(e*nfl + f)*s + b];
    end
    res = '0;
    for (int i = 0; i < nb; i++) res[8*i +: 8] = r[i];
    res[128] = !ok;
    return res;
  endfunction

  // Monitor: checks handshakes, holds and ready; pushes expectations on each acceptance.
  always @(negedge clk) begin
    logic [128:0] m64;
    logic [128:0] m128;
    int in_fire;
    int out_fire;
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_vld64", out_vld64, 1'b1);
        chk("hold_beat64", {out_err64, out_tag64, out_data64}, held64);
        chk("hold_vld128", out_vld128, 1'b1);
        chk("hold_beat128", {out_err128, out_tag128, out_data128}, held128);
      end
      chk("in_rdy64", in_rdy64, !(occ == 2 && !out_rdy));
      chk("in_rdy128", in_rdy128, !(occ == 2 && !out_rdy));
      if (out_vld64 && out_rdy) begin
        if (q64.size() == 0) begin
          chk("unexpected_out64", {out_err64, out_tag64, out_data64}, 'x);
        end else begin
          chk("beat64", {out_err64, out_tag64, out_data64}, q64.pop_front());
        end
      end
      if (out_vld128 && out_rdy) begin
        if (q128.size() == 0) begin
          chk("unexpected_out128", {out_err128, out_tag128, out_data128}, 'x);
        end else begin
          chk("beat128", {out_err128, out_tag128, out_data128}, q128.pop_front());
        end
      end
      stall_prev = out_vld64 && !out_rdy && !flush;
      held64  = {out_err64, out_tag64, out_data64};
      held128 = {out_err128, out_tag128, out_data128};
      in_fire  = (in_vld && in_rdy64) ? 1 : 0;
      out_fire = (out_vld64 && out_rdy) ? 1 : 0;
      if (flush) begin
        q64.delete();
        q128.delete();
        occ = 0;
      end else begin
        if (in_fire != 0) begin
          m64  = model(8, in_dir, int'(in_sew), int'(in_nf), int'(in_rot), in_data);
          m128 = model(16, in_dir, int'(in_sew), int'(in_nf), int'(in_rot), in_data);
          if (dexp64_en) m64 = {dexp64[64], 64'h0, dexp64[63:0]};
          if (dexp128_en) m128 = dexp128;
          q64.push_back({m64[128], in_tag, m64[63:0]});
          q128.push_back({m128[128], in_tag, m128[127:0]});
        end
        occ = occ + in_fire - out_fire;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 just after acceptance.
  task automatic send(input bit dir, input bit [1:0] sew, input bit [1:0] nf,
                      input bit [3:0] rot, input logic [127:0] data);
    int n;
    in_vld  = 1'b1;
    in_dir  = dir;
    in_sew  = sew;
    in_nf   = nf;
    in_rot  = rot;
    in_data = data;
    in_tag  = tag_ctr;
    tag_ctr = tag_ctr + 4'd1;
    n = 0;
    @(negedge clk);
    while (!in_rdy64 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    dexp64_en = 1'b0;
    dexp128_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_rdy = 1'b1;
    n = 0;
    while ((q64.size() != 0 || q128.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain64_empty", q64.size(), 0);
    chk("drain128_empty", q128.size(), 0);
    step();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] x;
    logic [128:0] y;
    bit [1:0] sw, nf;
    bit [3:0] rt;
    bit done;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld64", out_vld64, 1'b0);
    chk("rst_beat64", {out_err64, out_tag64, out_data64}, 69'h0);
    chk("rst_vld128", out_vld128, 1'b0);
    chk("rst_beat128", {out_err128, out_tag128, out_data128}, 133'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_rdy64", in_rdy64, 1'b1);
    mon_en = 1'b1;
    step();

    // Basic transpose / rotate vectors with exact latency on the first beat.
    dexp64_en = 1'b1; dexp64 = {1'b0, 64'h0703060205010400};
    send(1'b1, 2'd0, 2'd1, 4'd0, {rnd128() >> 64, 64'h0706050403020100});
    @(negedge clk);
    chk("lat1_cycle1_vld", out_vld64, 1'b0);
    @(negedge clk);
    chk("lat1_cycle2_vld", out_vld64, 1'b1);
    step();
    dexp64_en = 1'b1; dexp64 = {1'b0, 64'h0706050403020100};
    send(1'b0, 2'd0, 2'd1, 4'd0, {rnd128() >> 64, 64'h0703060205010400});
    dexp64_en = 1'b1; dexp64 = {1'b0, 64'h0504030201000706};
    send(1'b1, 2'd0, 2'd0, 4'd2, {rnd128() >> 64, 64'h0706050403020100});
    dexp64_en = 1'b1; dexp64 = {1'b0, 64'h0706050403020100};
    send(1'b0, 2'd0, 2'd0, 4'd2, {rnd128() >> 64, 64'h0504030201000706});
    dexp64_en = 1'b1; dexp64 = {1'b1, 64'h0605040302010007};
    send(1'b1, 2'd3, 2'd1, 4'd1, {rnd128() >> 64, 64'h0706050403020100});
    dexp64_en = 1'b1; dexp64 = {1'b0, 64'h0706050403020100};
    send(1'b1, 2'd0, 2'd0, 4'd0, {rnd128() >> 64, 64'h0706050403020100});
    x = rnd128();
    dexp128_en = 1'b1; dexp128 = {1'b0, x};
    send(1'b1, 2'd1, 2'd3, 4'd0, x);
    drain();

    // Mid-stream stall of three cycles with continuous input.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), rnd128());
      end
      begin
        repeat (3) step();
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_in_rdy", in_rdy64, 1'b0);
        chk("stall_out_vld", out_vld64, 1'b1);
        step();
        out_rdy = 1'b1;
      end
    join
    drain();

    // Flush with a full pipe plus a pending input beat.
    out_rdy = 1'b0;
    send(1'b1, 2'd0, 2'd1, 4'd0, rnd128());
    send(1'b0, 2'd1, 2'd0, 4'd3, rnd128());
    in_vld = 1'b1;
    in_data = rnd128();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk("flush_vld64", out_vld64, 1'b0);
    chk("flush_vld128", out_vld128, 1'b0);
    out_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_quiet", out_vld64, 1'b0);
    end
    step();
    // Beat accepted in the flush cycle on an empty pipe is dropped.
    in_vld = 1'b1;
    in_data = rnd128();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_vld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_accept_quiet", {out_vld64, out_vld128}, 2'b00);
    end
    step();
    send(1'b1, 2'd2, 2'd1, 4'd5, rnd128());
    @(negedge clk);
    chk("post_flush_cycle1", out_vld64, 1'b0);
    @(negedge clk);
    chk("post_flush_cycle2", out_vld64, 1'b1);
    step();
    drain();

    // Random modes under random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++)
          send(1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), rnd128());
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Write then read with the same mode restores the original data.
    for (int i = 0; i < 20; i++) begin
      sw = 2'($urandom);
      nf = 2'($urandom);
      rt = 4'($urandom);
      x = rnd128();
      send(1'b1, sw, nf, rt, x);
      y = model(16, 1'b1, int'(sw), int'(nf), int'(rt), x);
      dexp128_en = 1'b1;
      dexp128 = {y[128], x};
      send(1'b0, sw, nf, rt, y[127:0]);
    end
    drain();

    // Asynchronous reset with beats in flight.
    out_rdy = 1'b0;
    send(1'b1, 2'd0, 2'd1, 4'd0, rnd128());
    send(1'b1, 2'd0, 2'd1, 4'd0, rnd128());
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_vld64", out_vld64, 1'b0);
    chk("async_rst_vld128", out_vld128, 1'b0);
    chk("async_rst_in_rdy", in_rdy64, 1'b1);
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
